instruction_fetch_stage: RTL

//  Fetch front end feeding the instruction ROM. Owns the fetch PC and drives the ROM byte address.

---
 rtl/mips_fetch_pkg.sv | 16 +
 rtl/fetch_buffer_2.sv | 64 ++++++
 rtl/instruction_fetch_stage.sv | 84 ++++++++
 3 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types for the MIPS fetch front end: reset PC, FSM states and the fetch buffer entry.
package mips_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_2.sv
// Two-entry in-order FIFO of fetch entries; slot0 is always the head so it stays stable under stall.
module fetch_buffer_2
  import mips_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [1:0]   count
);

  fetch_entry_t slot0_q, slot0_d, slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) slot0_d = din;
          else                 slot1_d = din;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Count stays put; the new entry lands behind whatever remains after the pop.
          if (count_q == 2'd1) begin
            slot0_d = din;
          end else begin
            slot0_d = slot1_q;
            slot1_d = din;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign dout  = slot0_q;
  assign count = count_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch front end: owns the fetch PC, checks fetch legality, buffers ROM words and presents them
// to decode over valid/ready, with redirect and a sticky fault state.
module instruction_fetch_stage
  import mips_fetch_pkg::*;
#(
  parameter int unsigned     DATA_WIDTH   = 32,
  parameter logic [31:0]     RESET_PC     = RESET_PC_DEFAULT,
  parameter int unsigned     MEMORY_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Enable_i,
  input  logic                  Redirect_i,
  input  logic [DATA_WIDTH-1:0] RedirectPC_i,
  output logic [DATA_WIDTH-1:0] Address_o,
  input  logic [DATA_WIDTH-1:0] Instruction_i,
  input  logic                  Ready_i,
  output logic                  Valid_o,
  output logic [DATA_WIDTH-1:0] Instruction_o,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic [DATA_WIDTH-1:0] PCPlus4_o,
  output logic                  Fault_o
);

  logic [DATA_WIDTH-1:0] fpc_q, fpc_d;
  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] offset;
  logic                  bad, pop, push;
  fetch_entry_t          buf_din, buf_dout;
  logic [1:0]            buf_count;

  assign offset = fpc_q - RESET_PC;
  assign bad    = (fpc_q[1:0] != 2'b00) || (fpc_q < RESET_PC) ||
                  ((offset >> 2) >= DATA_WIDTH'(MEMORY_DEPTH));
  assign pop    = Valid_o & Ready_i;
  assign push   = (state_q == RUN) & Enable_i & ~Redirect_i & ~bad &
                  ((buf_count != 2'd2) | pop);

  assign buf_din.pc    = fpc_q;
  assign buf_din.instr = Instruction_i;

  always_comb begin
    fpc_d   = fpc_q;
    state_d = state_q;
    if (Redirect_i) begin
      fpc_d   = RedirectPC_i;
      state_d = RUN;
    end else if (push) begin
      fpc_d = fpc_q + DATA_WIDTH'(4);
    end else if ((state_q == RUN) && Enable_i && bad) begin
      state_d = FAULT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc_q   <= RESET_PC;
      state_q <= RUN;
    end else begin
      fpc_q   <= fpc_d;
      state_q <= state_d;
    end
  end

  fetch_buffer_2 u_buffer (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (Redirect_i),
    .din   (buf_din),
    .dout  (buf_dout),
    .count (buf_count)
  );

  // Empty buffer forces the head outputs to zero rather than exposing stale slot contents.
  assign Valid_o       = (buf_count != 2'd0);
  assign Instruction_o = Valid_o ? buf_dout.instr : '0;
  assign PC_o          = Valid_o ? buf_dout.pc : '0;
  assign PCPlus4_o     = Valid_o ? (buf_dout.pc + DATA_WIDTH'(4)) : '0;
  assign Address_o     = fpc_q;
  assign Fault_o       = (state_q == FAULT) && (buf_count == 2'd0);

endmodule
